// File: rtl/sram_2port_bank_ctrl.sv
// -----------------------------------------------------------------------------
// sram_2port_bank_ctrl
//
// WIDTH x DEPTH two-port SRAM bank with a built-in Bennett-style phase
// sequencer. Port A reads or writes. Port B only reads. Every accepted access
// runs one reversible cycle:
//   - CHARGE ramps the power-clock phases up one per clock.
//   - ACCESS fires the word lines for one cycle.
//   - DISCHARGE ramps the phases down in reverse order.
//   - DONE pulses the acks.
// Both ports are served in the same cycle when both are requested.
//
// Optional feature: define SRAM_WRITE_BYPASS_EN for write-through on a
// same-address collision between an A write and a B read. In that case
// rdata_b returns wdata_a. Without the macro, B reads the old contents.
//
// Ports:
//   clk                      system clock, rising edge
//   reset                    asynchronous active-low reset
//   req_a, we_a, addr_a,     port A request (level), write enable,
//   wdata_a                  address and write data
//   rdata_a, ack_a           port A read data (held) and completion pulse
//   req_b, addr_b            port B read request (level) and address
//   rdata_b, ack_b           port B read data (held) and completion pulse
//   clkp                     power-clock phase vector (thermometer code)
//   word_a, word_b           one-hot word lines, active only in ACCESS
//   instflag                 high only in ACCESS
//   busy                     high in every state except IDLE
// -----------------------------------------------------------------------------
module sram_2port_bank_ctrl #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 16,
    parameter  int PHASES = 5,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [AW-1:0]     addr_a,
    input  logic [WIDTH-1:0]  wdata_a,
    output logic [WIDTH-1:0]  rdata_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic [AW-1:0]     addr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              ack_b,
    output logic [PHASES-1:0] clkp,
    output logic [DEPTH-1:0]  word_a,
    output logic [DEPTH-1:0]  word_b,
    output logic              instflag,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, CHARGE, ACCESS, DISCHARGE, DONE} state_e;

    // DEPTH need not be a power of two, so compare one bit wider than AW.
    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic [PHASES-1:0]   clkp_q, clkp_d;
    logic                act_a_q, act_a_d, act_b_q, act_b_d, we_a_q, we_a_d;
    logic [AW-1:0]       addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [WIDTH-1:0]    wdata_a_q, wdata_a_d;
    logic [WIDTH-1:0]    hold_a_q, hold_b_q, rdata_a_q, rdata_b_q;
    logic [WIDTH-1:0]    mem [DEPTH];
    logic                in_a, in_b;
    logic [WIDTH-1:0]    rd_a, rd_b;

    assign in_a = ({1'b0, addr_a_q} < DEPTH_LIM);
    assign in_b = ({1'b0, addr_b_q} < DEPTH_LIM);

    // Out-of-range reads return zero rather than indexing past the array.
    assign rd_a = in_a ? mem[addr_a_q] : '0;
`ifdef SRAM_WRITE_BYPASS_EN
    assign rd_b = !in_b ? '0 :
                  (act_a_q && we_a_q && (addr_a_q == addr_b_q)) ? wdata_a_q :
                  mem[addr_b_q];
`else
    // The array is written at the same edge that captures rd_b, so B sees the old word.
    assign rd_b = in_b ? mem[addr_b_q] : '0;
`endif

    // Next-state logic. The phase vector is registered alongside the state.
    // The first CHARGE cycle therefore already shows clkp[0].
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d   = state_q;
        clkp_d    = clkp_q;
        act_a_d   = act_a_q;
        act_b_d   = act_b_q;
        we_a_d    = we_a_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        wdata_a_d = wdata_a_q;
        unique case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    state_d   = CHARGE;
                    clkp_d    = PHASES'(1);
                    act_a_d   = req_a;
                    act_b_d   = req_b;
                    we_a_d    = we_a;
                    addr_a_d  = addr_a;
                    addr_b_d  = addr_b;
                    wdata_a_d = wdata_a;
                end
            end
            CHARGE: begin
                if (&clkp_q) state_d = ACCESS;
                else         clkp_d  = (clkp_q << 1) | PHASES'(1);
            end
            ACCESS: begin
                state_d = DISCHARGE;
                clkp_d  = clkp_q >> 1;
            end
            DISCHARGE: begin
                // The last DISCHARGE cycle is the one that shows clkp == 0.
                if (clkp_q == '0) state_d = DONE;
                else              clkp_d  = clkp_q >> 1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            clkp_q    <= '0;
            act_a_q   <= 1'b0;
            act_b_q   <= 1'b0;
            we_a_q    <= 1'b0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            wdata_a_q <= '0;
            hold_a_q  <= '0;
            hold_b_q  <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            clkp_q    <= clkp_d;
            act_a_q   <= act_a_d;
            act_b_q   <= act_b_d;
            we_a_q    <= we_a_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            wdata_a_q <= wdata_a_d;
            if (state_q == ACCESS) begin
                if (act_a_q && !we_a_q) hold_a_q <= rd_a;
                if (act_b_q)            hold_b_q <= rd_b;
            end
            // Read data becomes visible together with the ack pulse.
            if (state_d == DONE) begin
                if (act_a_q && !we_a_q) rdata_a_q <= hold_a_q;
                if (act_b_q)            rdata_b_q <= hold_b_q;
            end
        end
    end

    // NOTE: the array has no reset and keeps its contents across reset.
    // An aborted access never reaches ACCESS, so a pending write is dropped.
    always_ff @(posedge clk) begin
        if (state_q == ACCESS && act_a_q && we_a_q && in_a) mem[addr_a_q] <= wdata_a_q;
    end

    always_comb begin
        word_a = '0;
        word_b = '0;
        if (state_q == ACCESS) begin
            if (act_a_q && in_a) word_a[addr_a_q] = 1'b1;
            if (act_b_q && in_b) word_b[addr_b_q] = 1'b1;
        end
    end

    assign clkp     = clkp_q;
    assign instflag = (state_q == ACCESS);
    assign busy     = (state_q != IDLE);
    assign ack_a    = (state_q == DONE) && act_a_q;
    assign ack_b    = (state_q == DONE) && act_b_q;
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;

endmodule

// File: tb/tb_sram_2port_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_2port_bank_ctrl
//
// Bench for sram_2port_bank_ctrl, built with DEPTH=12 so that address 13 is
// out of range. The stimulus issues directed accesses and pushes the expected
// read data per port into queues. A monitor on the falling edge pops a queue
// entry and compares rdata whenever an ack is presented. The access task also
// checks the cycle-by-cycle clkp ramp, the word lines, instflag, busy and the
// ack timing.
// -----------------------------------------------------------------------------
module tb_sram_2port_bank_ctrl;

    localparam int DEPTH = 12;

    logic        clk, reset;
    logic        req_a, we_a, req_b;
    logic [3:0]  addr_a, addr_b;
    logic [7:0]  wdata_a, rdata_a, rdata_b;
    logic        ack_a, ack_b, instflag, busy;
    logic [4:0]  clkp;
    logic [11:0] word_a, word_b;

    int n_err = 0;
    int n_chk = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;

    // clkp per cycle after the acceptance edge: ramp up, ACCESS, ramp down, DONE.
    localparam logic [4:0] CLKP_SEQ [12] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111,
                                             5'b11111, 5'b11111, 5'b01111, 5'b00111,
                                             5'b00011, 5'b00001, 5'b00000, 5'b00000};
    // Array contents after the preload, the 0xA5 write and the collision write.
    localparam logic [7:0] SWEEP_EXP [12] = '{8'h00, 8'h11, 8'h22, 8'hA5, 8'h44, 8'h3C,
                                              8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB};
`ifdef SRAM_WRITE_BYPASS_EN
    localparam logic [7:0] COLL_EXP = 8'h3C;
`else
    localparam logic [7:0] COLL_EXP = 8'h11;
`endif

    sram_2port_bank_ctrl #(.WIDTH(8), .DEPTH(DEPTH), .PHASES(5)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .rdata_a(rdata_a), .ack_a(ack_a),
        .req_b(req_b), .addr_b(addr_b), .rdata_b(rdata_b), .ack_b(ack_b),
        .clkp(clkp), .word_a(word_a), .word_b(word_b),
        .instflag(instflag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare read data whenever an ack is presented.
    always @(negedge clk) begin
        if (reset) begin
            if (ack_a) begin
                if (q_a.size() == 0) check("ack_a_unexpected", 32'd1, 32'd0);
                else check("rdata_a", rdata_a, q_a.pop_front());
            end
            if (ack_b) begin
                if (q_b.size() == 0) check("ack_b_unexpected", 32'd1, 32'd0);
                else check("rdata_b", rdata_b, q_b.pop_front());
            end
        end
    end

    // One complete access. Requests are held until the ack cycle. The other
    // inputs are scrambled while busy to show that they are ignored.
    task automatic access(input logic ra, input logic wa, input logic rb,
                          input logic [3:0] aa, input logic [3:0] ab,
                          input logic [7:0] wd, input logic [7:0] exp_a,
                          input logic [7:0] exp_b);
        logic [11:0] exp_wa, exp_wb;
        @(negedge clk);
        req_a = ra; we_a = wa; addr_a = aa; wdata_a = wd;
        req_b = rb; addr_b = ab;
        if (ra) begin
            if (!wa) last_a = exp_a;
            q_a.push_back(last_a);
        end
        if (rb) begin
            last_b = exp_b;
            q_b.push_back(last_b);
        end
        @(posedge clk); #1;
        addr_a = ~aa; addr_b = ~ab; wdata_a = ~wd; we_a = ~wa;
        for (int k = 0; k < 12; k++) begin
            exp_wa = (k == 5 && ra && aa < 4'd12) ? (12'd1 << aa) : 12'd0;
            exp_wb = (k == 5 && rb && ab < 4'd12) ? (12'd1 << ab) : 12'd0;
            check("busy", busy, 32'd1);
            check("clkp", clkp, CLKP_SEQ[k]);
            check("instflag", instflag, (k == 5) ? 32'd1 : 32'd0);
            check("word_a", word_a, exp_wa);
            check("word_b", word_b, exp_wb);
            check("ack_a_timing", ack_a, (k == 11 && ra) ? 32'd1 : 32'd0);
            check("ack_b_timing", ack_b, (k == 11 && rb) ? 32'd1 : 32'd0);
            if (k == 11) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("busy_idle", busy, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; addr_b = '0;
        #2;
        check("rst_clkp", clkp, 32'd0);
        check("rst_word_a", word_a, 32'd0);
        check("rst_word_b", word_b, 32'd0);
        check("rst_rdata_a", rdata_a, 32'd0);
        check("rst_rdata_b", rdata_b, 32'd0);
        check("rst_acks", {ack_a, ack_b}, 32'd0);
        check("rst_instflag", instflag, 32'd0);
        check("rst_busy", busy, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Preload i*0x11, then give address 5 the old value 0x11.
        for (int i = 0; i < 12; i++) access(1, 1, 0, 4'(i), 4'd0, 8'(i * 17), 8'h00, 8'h00);
        access(1, 1, 0, 4'd5, 4'd0, 8'h11, 8'h00, 8'h00);

        // Write then read address 3.
        access(1, 1, 0, 4'd3, 4'd0, 8'hA5, 8'h00, 8'h00);
        access(1, 0, 0, 4'd3, 4'd0, 8'h00, 8'hA5, 8'h00);

        // Collision: A writes 5 while B reads 5.
        access(1, 1, 1, 4'd5, 4'd5, 8'h3C, 8'h00, COLL_EXP);

        // Dual reads: different addresses, then the same address.
        access(1, 0, 1, 4'd2, 4'd9, 8'h00, 8'h22, 8'h99);
        access(1, 0, 1, 4'd4, 4'd4, 8'h00, 8'h44, 8'h44);

        // Out-of-range write is dropped. Out-of-range reads return 0.
        access(1, 1, 0, 4'd13, 4'd0, 8'hFF, 8'h00, 8'h00);
        access(1, 0, 1, 4'd13, 4'd13, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 12; i++) access(1, 0, 0, 4'(i), 4'd0, 8'h00, SWEEP_EXP[i], 8'h00);

        // Reset during the third CHARGE cycle of a write to address 7.
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 4'd7; wdata_a = 8'h5A;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("clkp_third_charge", clkp, 32'h07);
        reset = 1'b0;
        #1;
        check("midrst_clkp", clkp, 32'd0);
        check("midrst_words", {word_a, word_b}, 32'd0);
        check("midrst_rdata", {rdata_a, rdata_b}, 32'd0);
        check("midrst_flags", {ack_a, ack_b, instflag, busy}, 32'd0);
        req_a = 1'b0; we_a = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        last_a = 8'h00; last_b = 8'h00;
        access(1, 0, 1, 4'd7, 4'd7, 8'h00, 8'h77, 8'h77);

        // Hold req_b across the ack: a second access starts after one IDLE cycle.
        @(negedge clk);
        req_b = 1'b1; addr_b = 4'd9;
        q_b.push_back(8'h99); q_b.push_back(8'h99); last_b = 8'h99;
        @(posedge clk); #1;
        n = 0;
        while (!ack_b && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold_first_latency", n, 32'd11);
        @(posedge clk); #1;
        check("hold_busy_gap", busy, 32'd0);
        @(posedge clk); #1;
        check("hold_busy_restart", busy, 32'd1);
        req_b = 1'b0;
        n = 0;
        while (!ack_b && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold_second_latency", n, 32'd11);
        @(posedge clk); #1;
        check("hold_busy_end", busy, 32'd0);

        repeat (3) @(posedge clk);
        check("q_a_drained", q_a.size(), 32'd0);
        check("q_b_drained", q_b.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_2port_bank_ctrl.md
Name: sram_2port_bank_ctrl

Overview:
- Parametrised WIDTH x DEPTH two-port SRAM bank with a built-in Bennett-style phase sequencer.
- Port A is read/write; port B is read-only.
- Every access runs one reversible cycle: supply phases ramp up one per clock, word lines fire, then phases ramp down in reverse order.
- Successor to the 1-bit two-port cell; it sits between the adiabatic datapath and the register/scratch storage.

Parameters:
- WIDTH, 8, data bits per word.
- DEPTH, 16, number of words; need not be a power of two.
- PHASES, 5, number of Bennett power-clock phases in the ramp.
- AW, $clog2(DEPTH) (min 1), address width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_a  in  1  port A request (level).
- we_a  in  1  port A write enable; sampled with req_a.
- addr_a  in  AW  port A address.
- wdata_a  in  WIDTH  port A write data.
- rdata_a  out  WIDTH  port A read data.
- ack_a  out  1  port A completion pulse.
- req_b  in  1  port B read request (level).
- addr_b  in  AW  port B address.
- rdata_b  out  WIDTH  port B read data.
- ack_b  out  1  port B completion pulse.
- clkp  out  PHASES  power-clock phase vector.
- word_a  out  DEPTH  one-hot port A word lines.
- word_b  out  DEPTH  one-hot port B word lines.
- instflag  out  1  high only during the ACCESS state.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE.
  - clkp, word_a, word_b, rdata_a, rdata_b, ack_a, ack_b, instflag and busy all go to 0.
  - The memory array is not cleared.
- FSM states: IDLE, CHARGE, ACCESS, DISCHARGE, DONE.
- IDLE:
  - If req_a or req_b is high at an edge, latch the active request flags, we_a, both addresses and wdata_a, then go to CHARGE with phase counter = 0.
  - Otherwise stay in IDLE.
- CHARGE:
  - Each cycle sets clkp[k], k = 0..PHASES-1, cumulatively (thermometer code).
  - Moves to ACCESS the edge after clkp is all ones.
- ACCESS, one cycle:
  - instflag = 1.
  - word_a/word_b are one-hot on the latched addresses, but only for ports with an active request.
  - Write: committed at the edge leaving ACCESS.
  - Reads: captured into internal holding registers at that same edge.
- DISCHARGE:
  - Clears clkp bits highest-first, one per cycle.
  - Lasts PHASES cycles and ends with clkp = 0.
- DONE, one cycle:
  - ack_a/ack_b pulse high only for ports that were served.
  - rdata_a/rdata_b update for served read ports.
  - Next state is IDLE.
- Latency: acceptance edge E0 -> ack high after edge E0 + 2*PHASES + 1 (11 edges at default).
  - Back-to-back requests are spaced 2*PHASES + 3 edges apart at minimum.
- Handshake:
  - Requests are sampled only in IDLE; changes to req/addr/data while busy are ignored.
  - The requester drops req on the ack cycle. If req is still high in the following IDLE, it is treated as a new access.
- rdata holding:
  - rdata holds until the next served read on that port.
  - A port A write leaves rdata_a unchanged.
- Both ports served in one Bennett cycle if both are requested.
- Collision (A write and B read, same address, same cycle): B returns the old contents (read-before-write).
- A read and B read at the same address: both return the same word.
- Out-of-range address (addr >= DEPTH):
  - No word line fires and writes are dropped.
  - Reads return 0.
  - ack is still issued.
- Reset mid-operation: clkp and word lines drop to 0 immediately. A write is not committed unless its ACCESS edge has already completed.

Optional Feature:
- Macro SRAM_WRITE_BYPASS_EN.
- Defined: on a same-address collision between an A write and a B read, rdata_b returns wdata_a (write-through). Timing is unchanged.
- Undefined: read-before-write, as above.

Test Plan:
- Reset, then port A write addr 3 = 0xA5, then port A read addr 3:
  - ack_a after 11 edges.
  - rdata_a = 0xA5.
  - clkp sequence 00001, 00011, ..., 11111, then 01111, ..., 00000.
- Simultaneous A write addr 5 = 0x3C and B read addr 5 (old value 0x11):
  - Macro off: rdata_b = 0x11.
  - Macro on: rdata_b = 0x3C.
  - Both acks in the same cycle.
- Simultaneous A read addr 2 and B read addr 9 (preloaded 0x22 / 0x99):
  - Both acks fire.
  - word_a[2] and word_b[9] high only in the instflag cycle.
- DEPTH=12: write addr 13 = 0xFF, then read addr 13:
  - ack issued, no word line fires, rdata = 0.
  - Addresses 0..11 unchanged.
- Assert reset in the third CHARGE cycle of a write to addr 7:
  - All outputs go to 0 immediately.
  - After release, a read of addr 7 returns its previous value.
- Hold req_b high across ack:
  - A second access starts on the IDLE edge.
  - busy drops for exactly one cycle between the two accesses.
